// File: rtl/ddc_mix_cic.sv
// Mixer plus 3-stage CIC decimator (R = 2^rlog2) for the DDC front end.
// Define DDC_MIX_CIC_ROUND_EN for round-half-up output; default truncates.
module ddc_mix_cic #(
    parameter int adw   = 14,
    parameter int mpr   = 13,
    parameter int rlog2 = 6,
    parameter int odw   = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clken,
    input  logic signed [adw-1:0] adc_i,
    input  logic signed [mpr-1:0] nco_i,
    input  logic                  in_valid,
    output logic signed [odw-1:0] bb_o,
    output logic                  out_valid
);

    localparam int pw = adw + mpr;
    localparam int mw = adw + mpr - 1;
    localparam int aw = mw + 3 * rlog2;
    localparam int sh = aw - odw;

    logic signed [pw-1:0]  prod;
    logic signed [mw-1:0]  p;
    logic signed [mw-1:0]  mix_r;
    logic signed [aw-1:0]  mix_x;
    logic signed [aw-1:0]  i1, i2, i3;
    logic signed [aw-1:0]  c1, c2;
    logic signed [aw-1:0]  d1, d2, d3;
    logic signed [aw-1:0]  c3_n;
    logic signed [odw-1:0] bb_n;
    logic [rlog2-1:0]      dcnt;
    logic                  accept;
    logic                  tick;
    logic                  vld_r;

    assign prod = pw'(adc_i) * pw'(nco_i);

    // Only (-max)*(-max) lands outside mw bits; clamp it to +max.
    always_comb begin
        p = prod[mw-1:0];
        if (prod[mw] ^ prod[mw-1]) begin
            p = {1'b0, {(mw-1){1'b1}}};
        end
    end

    assign mix_x  = {{(aw-mw){mix_r[mw-1]}}, mix_r};
    assign accept = clken & in_valid;
    assign tick   = accept & (&dcnt);
    assign c3_n   = c2 - d3;

`ifdef DDC_MIX_CIC_ROUND_EN
    logic signed [aw-1:0] rnd;

    assign rnd = c3_n + (aw'(1) << (sh - 1));

    always_comb begin
        bb_n = odw'(rnd >>> sh);
        if (!c3_n[aw-1] && rnd[aw-1]) begin
            bb_n = {1'b0, {(odw-1){1'b1}}};
        end
    end
`else
    always_comb begin
        bb_n = odw'(c3_n >>> sh);
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            mix_r <= '0;
            i1    <= '0;
            i2    <= '0;
            i3    <= '0;
            c1    <= '0;
            c2    <= '0;
            d1    <= '0;
            d2    <= '0;
            d3    <= '0;
            dcnt  <= '0;
            bb_o  <= '0;
            vld_r <= 1'b0;
        end else begin
            if (accept) begin
                mix_r <= p;
                i1    <= i1 + mix_x;
                i2    <= i2 + i1;
                i3    <= i3 + i2;
                dcnt  <= dcnt + rlog2'(1);
            end
            // Comb stages read registered predecessors, so C3 lags two ticks.
            if (tick) begin
                c1   <= i3 - d1;
                d1   <= i3;
                c2   <= c1 - d2;
                d2   <= c1;
                d3   <= c2;
                bb_o <= bb_n;
            end
            if (clken) begin
                vld_r <= tick;
            end
        end
    end

    assign out_valid = vld_r & clken & ~reset;

endmodule
